// File: rtl/conv_encoder_framed.sv
// Framed rate-1/2 convolutional encoder: FRAME_LEN info bits plus K-1 zero tail bits, symbol registered 1 cycle after accept.
// Back-pressure: ready_o is high only in DATA; enable_i is dropped elsewhere, and the tail flushes unconditionally.
module conv_encoder_framed #(
  parameter int           K         = 3,
  parameter logic [K-1:0] G0        = 3'b111,
  parameter logic [K-1:0] G1        = 3'b101,
  parameter int           FRAME_LEN = 64,
  parameter int           CW        = $clog2(FRAME_LEN + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       enable_i,
  input  logic       d_in,
  output logic       ready_o,
  output logic       valid_o,
  output logic [1:0] d_out,
  output logic       tail_o,
  output logic       frame_done_o
);

  localparam int TW = (K > 2) ? $clog2(K - 1) : 1;

  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

  state_t        state;
  logic [K-2:0]  sr;
  logic [CW-1:0] count;
  logic [TW-1:0] tail_cnt;

  logic          enc_go;
  logic          enc_bit;
  logic [K-1:0]  win;

  // The window's top bit is the bit being encoded; the tail feeds zeros.
  always_comb begin
    enc_go  = (state == DATA && enable_i) || (state == TAIL);
    enc_bit = (state == DATA) ? d_in : 1'b0;
    win     = {enc_bit, sr};
  end

  assign ready_o = (state == DATA);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      sr           <= '0;
      count        <= '0;
      tail_cnt     <= '0;
      valid_o      <= 1'b0;
      d_out        <= 2'b00;
      tail_o       <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      valid_o      <= enc_go;
      tail_o       <= (state == TAIL);
      frame_done_o <= 1'b0;
      if (enc_go) begin
        d_out <= {^(win & G0), ^(win & G1)};
        sr    <= win[K-1:1];
      end
      case (state)
        IDLE: begin
          if (start_i) begin
            state <= DATA;
            sr    <= '0;
            count <= '0;
          end
        end
        DATA: begin
          if (enable_i) begin
            count <= count + CW'(1);
            if (count == CW'(FRAME_LEN - 1)) begin
              state    <= TAIL;
              tail_cnt <= '0;
            end
          end
        end
        TAIL: begin
          tail_cnt <= tail_cnt + TW'(1);
          // Last flush bit: the register is back to zero after this edge.
          if (tail_cnt == TW'(K - 2)) begin
            state        <= IDLE;
            frame_done_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/conv_encoder_framed.md
Name: conv_encoder_framed

Overview:
- Rate-1/2 convolutional encoder, the transmit end feeding the channel/error-injection stage and the Viterbi decoder.
- Accepts a fixed-length frame of information bits under a start/enable handshake.
- After the last information bit it appends K-1 zero tail bits, so the trellis ends in state 0. The decoder can then terminate traceback at a known state.
- Output is registered: a 2-bit symbol plus a valid strobe and frame markers.

Parameters:
K, 3, constraint length (K>=2); shift register holds K-1 past bits
G0, 3'b111, generator for d_out[1], width K, bit K-1 taps current input
G1, 3'b101, generator for d_out[0], width K, bit K-1 taps current input
FRAME_LEN, 64, information bits per frame (>=1)
CW, $clog2(FRAME_LEN+1), frame counter width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
start_i  input  1  frame start request; honoured only in IDLE
enable_i  input  1  d_in valid; honoured only while ready_o=1
d_in  input  1  information bit
ready_o  output  1  encoder accepting information bits (DATA state)
valid_o  output  1  d_out holds a new symbol this cycle
d_out  output  2  encoded symbol {parity G0, parity G1}
tail_o  output  1  current symbol is a tail (flush) symbol
frame_done_o  output  1  one-cycle pulse with the last tail symbol

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, sr=0, count=0; ready_o=0, valid_o=0, d_out=2'b00, tail_o=0, frame_done_o=0.
- Reset mid-frame aborts the frame with no further output. The next frame needs a fresh start_i.
- Encoding window: w = {b, sr[K-2:0]}.
  - b is the bit being encoded; sr[K-2] is the most recent previous bit.
  - d_out[1] = XOR-reduce(w & G0); d_out[0] = XOR-reduce(w & G1).
  - After encoding, sr <= {b, sr[K-2:1]}.
- Latency: d_out/valid_o register one cycle after the accepting edge. valid_o is 0 on cycles with no accepted/tail bit, and d_out holds its last value.
- FSM, IDLE:
  - ready_o=0.
  - start_i=1 -> DATA; sr<=0; count<=0.
- FSM, DATA:
  - ready_o=1 (combinational from state).
  - enable_i=1: encode b=d_in, count<=count+1.
  - When the accepted bit makes count==FRAME_LEN -> TAIL; ready_o drops next cycle.
  - enable_i=0: no change; gaps of any length are allowed.
- FSM, TAIL:
  - ready_o=0.
  - Encodes b=0 on each of K-1 consecutive cycles unconditionally, one symbol per cycle.
  - Each tail symbol registers with tail_o=1.
  - The last tail symbol also has frame_done_o=1.
  - Then -> IDLE with sr==0.
- start_i in DATA/TAIL is ignored. enable_i outside DATA is ignored; the bit is dropped.
- start_i asserted in the same cycle IDLE is re-entered is ignored. IDLE is entered on the edge after the last tail bit, and start_i is sampled from the next cycle.
- tail_o and frame_done_o are registered alongside d_out and are 0 whenever valid_o=0.
- Frame length: exactly FRAME_LEN+K-1 valid symbols per frame. count never exceeds FRAME_LEN; there is no wrap.

Test Plan:
- K=3, G 7/5 octal, FRAME_LEN=4: start_i, then d_in 1,0,1,1 on consecutive enable_i cycles. Required d_out 11,10,00,01, then tail 01,11 with tail_o=1. frame_done_o is on the final 11. Total 6 valid_o pulses.
- Same frame with enable_i gaps of 0-3 random idle cycles between bits: identical symbol sequence. valid_o count=6; no valid_o during gaps.
- enable_i=1 with d_in=1 held in IDLE and TAIL: no output change, ready_o=0. start_i pulsed during DATA: frame unaffected.
- rst asserted mid-DATA after 2 bits: all outputs 0 immediately (asynchronous). A new start_i with bits 1,0,1,1 reproduces the first scenario exactly, confirming sr cleared.
- FRAME_LEN=64, random bits: bench reference model matches every symbol. Exactly 66 valid symbols per frame; sr==0 at IDLE. Back-to-back frames with start_i asserted the cycle after frame_done_o.
- Encoder feeding the existing Viterbi decoder over a clean channel, 256 random bits: decoded output equals input bits, zero bit errors.
